// File: rtl/hazard_stall_unit.sv
// LEGv8 load-use / CBZ-operand stall and IF/ID flush controller.
// Tracks EX/MEM destination shadows locally; counts stalls and flushes.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_Rn,
  input  logic [4:0]       ID_Rm,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_Reg2Loc,
  input  logic             ID_UsesRn,
  input  logic             ID_UsesRm,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_CondBranch,
  input  logic             ID_BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } shadow_t;

  shadow_t ex_q, ex_d;
  shadow_t mem_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] src_b;
  logic       ex_live, ex_ld_live, mem_ld_live;
  logic       h1, h2, h3, stall, flush;

  assign src_b = ID_Reg2Loc ? ID_Rd : ID_Rm;

  // X31 is the zero register, so it never carries a dependence
  assign ex_live     = ex_q.wr & (ex_q.rd != 5'd31);
  assign ex_ld_live  = ex_live & ex_q.ld;
  assign mem_ld_live = mem_q.wr & mem_q.ld & (mem_q.rd != 5'd31);

  assign h1 = ex_ld_live &
              ((ID_UsesRn & (ex_q.rd == ID_Rn)) |
               (ID_UsesRm & (ex_q.rd == src_b)));
  assign h2 = ID_CondBranch & ex_live & (ex_q.rd == src_b);
  assign h3 = ID_CondBranch & mem_ld_live & (mem_q.rd == src_b);

  assign stall = h1 | h2 | h3;
  assign flush = ID_BranchTaken & ~stall;

  assign PCWrite     = ~stall;
  assign IFIDWrite   = ~stall;
  assign IDEX_Bubble = stall;
  assign IFID_Flush  = flush;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.wr = ID_RegWrite;
      ex_d.ld = ID_MemRead & ID_RegWrite;
      ex_d.rd = ID_Rd;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
